debounce_multi: RTL and testbench
=================================

// Module: debounce_multi
// PURPOSE
//   N-channel debouncer for buttons/switches/keyboard lines. Synchronises each raw input,
//   filters bounce with a per-channel stability counter, emits the clean level plus
//   one-cycle rise/fall pulses. Sits between the board pins and the keyboard/UI logic.
// PARAMETERS
//   CHANNELS       4        number of independent input lines (>=1)
//   STABLE_CYCLES  500000   cycles a new level must hold before it is accepted (>=2)
//   SYNC_STAGES    2        synchroniser flip-flop depth (>=2)
//   RESET_VAL      1'b0     level loaded into synchroniser and stable state on reset
// PORTS
//   clk       in   1          system clock, all logic on posedge
//   rst_n     in   1          asynchronous active-low reset
//   raw_i     in   CHANNELS   asynchronous raw inputs
//   level_o   out  CHANNELS   debounced level
//   rise_o    out  CHANNELS   1-cycle pulse on accepted 0->1 transition
//   fall_o    out  CHANNELS   1-cycle pulse on accepted 1->0 transition
//   clr_i     in   CHANNELS   [DEBOUNCE_STICKY_EN only] clear sticky flags
//   sticky_o  out  CHANNELS   [DEBOUNCE_STICKY_EN only] latched "a rise occurred"
// BEHAVIOUR
//   - Reset (rst_n=0, async): sync chain = RESET_VAL, level_o = RESET_VAL, counters = 0,
//     rise_o = fall_o = 0, sticky_o = 0. No edge pulse on reset release.
//   - Per channel, per cycle; s = last synchroniser stage:
//       s == level         -> cnt <= 0 (any glitch restarts qualification)
//       s != level, cnt <  STABLE_CYCLES-1 -> cnt <= cnt+1
//       s != level, cnt == STABLE_CYCLES-1 -> level <= s, cnt <= 0, pulse rise/fall
//   - Counter width CNT_W = $clog2(STABLE_CYCLES); never wraps (cleared at terminal).
//   - Latency: clean input step on raw_i -> level_o change after exactly
//     SYNC_STAGES + STABLE_CYCLES clock edges; rise_o/fall_o asserted in that same cycle.
//   - rise_o/fall_o registered, high exactly 1 cycle, mutually exclusive per channel.
//   - Input toggling at period < STABLE_CYCLES: level_o never changes, no pulses.
//   - Channels fully independent; simultaneous transitions on several channels each
//     produce their own pulse in the same cycle.
//   - Reset mid-qualification: counter discarded, level_o returns to RESET_VAL; a held
//     input differing from RESET_VAL requalifies from zero after release.
// CONFIGURATION
//   DEBOUNCE_STICKY_EN defined: adds clr_i/sticky_o. sticky_o[i] sets on rise_o[i],
//     holds until clr_i[i]=1; set wins over clear in the same cycle; clr_i synchronous.
//   Undefined: ports and sticky registers absent; all other behaviour identical.
// STRUCTURE
//   - debounce_pkg: function cnt_width(stable_cycles), default constants
//     (DEF_STABLE_CYCLES, DEF_SYNC_STAGES), typedef for per-channel status struct
//     {level, rise, fall}.
//   - Sub-module debounce_chan: one channel (sync chain, counter, level, pulses);
//     debounce_multi generates CHANNELS instances plus optional sticky logic.
// TESTING  (CHANNELS=4, STABLE_CYCLES=8, SYNC_STAGES=2, RESET_VAL=0)
//   1 Reset release with raw_i=4'h0 -> level_o=0, no rise/fall for 20 cycles.
//   2 raw_i[0] 0->1 held -> level_o[0]=1 and rise_o[0]=1 exactly 10 cycles later, 1 cycle.
//   3 raw_i[1] toggles every 5 cycles for 100 cycles -> level_o[1]=0, no pulses.
//   4 raw_i[2] high 7 cycles then 1-cycle low glitch then high -> accept 10 cycles
//     after glitch ends, not before.
//   5 raw_i=4'hF same edge -> rise_o=4'hF in one cycle; then 4'h0 -> fall_o=4'hF
//     10 cycles later.
//   6 rst_n pulsed low at count 5 while raw_i[3]=1 -> level_o[3]=0 immediately;
//     level_o[3]=1 10 cycles after release. With DEBOUNCE_STICKY_EN: sticky_o[3]=1
//     until clr_i[3] pulsed.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared constants, types and helpers for the multi-channel debouncer.
package debounce_pkg;

  localparam int DEF_STABLE_CYCLES = 500000;
  localparam int DEF_SYNC_STAGES   = 2;

  typedef struct packed {
    logic level;
    logic rise;
    logic fall;
  } chan_status_t;

  // Counter width able to hold STABLE_CYCLES-1; never narrower than one bit.
  function automatic int cnt_width(input int stable_cycles);
    return (stable_cycles > 2) ? $clog2(stable_cycles) : 1;
  endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debounce channel: synchroniser chain, stability counter, accepted level
// and registered single-cycle rise/fall pulses.
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int   STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int   SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter logic RESET_VAL     = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         raw,
  output chan_status_t status
);

  localparam int               CNT_W    = cnt_width(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_s;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;

  assign sync_s = sync_q[SYNC_STAGES-1];

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, whatever order the blocks run in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
    end
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the if/else can leave a signal unassigned and infer a latch.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (sync_s != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync_s;
        rise_d  = sync_s;
        fall_d  = ~sync_s;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Reset loads the same level as the synchroniser, so release never pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      level_q <= RESET_VAL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign status.level = level_q;
  assign status.rise  = rise_q;
  assign status.fall  = fall_q;

endmodule

// File: rtl/debounce_multi.sv
// N-channel debouncer top. Define DEBOUNCE_STICKY_EN to add clr_i/sticky_o,
// a per-channel "rise occurred" flag held until cleared.
module debounce_multi
  import debounce_pkg::*;
#(
  parameter int   CHANNELS      = 4,
  parameter int   STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int   SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter logic RESET_VAL     = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] raw_i,
  output logic [CHANNELS-1:0] level_o,
  output logic [CHANNELS-1:0] rise_o,
  output logic [CHANNELS-1:0] fall_o
`ifdef DEBOUNCE_STICKY_EN
  ,
  input  logic [CHANNELS-1:0] clr_i,
  output logic [CHANNELS-1:0] sticky_o
`endif
);

  chan_status_t status [CHANNELS];

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    debounce_chan #(
      .STABLE_CYCLES(STABLE_CYCLES),
      .SYNC_STAGES  (SYNC_STAGES),
      .RESET_VAL    (RESET_VAL)
    ) u_chan (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (raw_i[g]),
      .status(status[g])
    );

    assign level_o[g] = status[g].level;
    assign rise_o[g]  = status[g].rise;
    assign fall_o[g]  = status[g].fall;
  end

`ifdef DEBOUNCE_STICKY_EN
  logic [CHANNELS-1:0] sticky_q;

  // A rise pulse sets the flag even when a clear arrives in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= '0;
    end else begin
      sticky_q <= rise_o | (sticky_q & ~clr_i);
    end
  end

  assign sticky_o = sticky_q;
`endif

endmodule

// File: tb/tb_debounce_multi.sv
// Directed bench for debounce_multi (4 channels, 8 stable cycles, 2 sync stages);
// expected pulses are queued with their due cycle and compared every cycle.
module tb_debounce_multi;

  localparam int LAT = 10;  // SYNC_STAGES + STABLE_CYCLES

  typedef struct {
    int         due;
    logic [3:0] rise;
    logic [3:0] fall;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] raw_i;
  logic [3:0] level_o, rise_o, fall_o;
`ifdef DEBOUNCE_STICKY_EN
  logic [3:0] clr_i;
  logic [3:0] sticky_o;
  logic [3:0] exp_sticky, sticky_nx, last_r;
`endif

  exp_t       exp_q[$];
  logic [3:0] exp_level, exp_r, exp_f;
  int         cyc    = 0;
  int         checks = 0;
  int         errors = 0;

  debounce_multi #(
    .CHANNELS     (4),
    .STABLE_CYCLES(8),
    .SYNC_STAGES  (2),
    .RESET_VAL    (1'b0)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .raw_i  (raw_i),
    .level_o(level_o),
    .rise_o (rise_o),
    .fall_o (fall_o)
`ifdef DEBOUNCE_STICKY_EN
    ,
    .clr_i   (clr_i),
    .sticky_o(sticky_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s cyc=%0d: observed %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [3:0] r, input logic [3:0] f);
    exp_t e;
    e.due  = cyc + LAT;
    e.rise = r;
    e.fall = f;
    exp_q.push_back(e);
  endtask

  task automatic flush_model();
    exp_q.delete();
    exp_level = '0;
    exp_r     = '0;
    exp_f     = '0;
`ifdef DEBOUNCE_STICKY_EN
    exp_sticky = '0;
    last_r     = '0;
`endif
  endtask

  // Advance n cycles, sampling 1 time unit after each rising edge.
  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
`ifdef DEBOUNCE_STICKY_EN
      sticky_nx = last_r | (exp_sticky & ~clr_i);
`endif
      @(posedge clk);
      #1;
      cyc++;
      if (!rst_n) begin
        flush_model();
      end else begin
        exp_r = '0;
        exp_f = '0;
        for (int j = exp_q.size() - 1; j >= 0; j--) begin
          if (exp_q[j].due == cyc) begin
            exp_r |= exp_q[j].rise;
            exp_f |= exp_q[j].fall;
            exp_q.delete(j);
          end
        end
        exp_level = (exp_level | exp_r) & ~exp_f;
`ifdef DEBOUNCE_STICKY_EN
        exp_sticky = sticky_nx;
        last_r     = exp_r;
`endif
      end
      check("level", level_o, exp_level);
      check("rise", rise_o, exp_r);
      check("fall", fall_o, exp_f);
`ifdef DEBOUNCE_STICKY_EN
      check("sticky", sticky_o, exp_sticky);
`endif
    end
  endtask

  initial begin
    rst_n = 1'b0;
    raw_i = 4'h0;
`ifdef DEBOUNCE_STICKY_EN
    clr_i = 4'h0;
`endif
    flush_model();
    step(3);

    // Quiet release: no pulses, level stays low.
    rst_n = 1'b1;
    step(20);

    // Clean rising step on channel 0.
    raw_i[0] = 1'b1;
    push_exp(4'b0001, 4'b0000);
    step(15);

    // Channel 1 toggling faster than the qualification window.
    for (int t = 0; t < 20; t++) begin
      raw_i[1] = ~raw_i[1];
      step(5);
    end
    step(5);

    // Channel 2: seven high cycles, one-cycle glitch, then held high.
    raw_i[2] = 1'b1;
    step(7);
    raw_i[2] = 1'b0;
    step(1);
    raw_i[2] = 1'b1;
    push_exp(4'b0100, 4'b0000);
    step(15);

`ifdef DEBOUNCE_STICKY_EN
    clr_i = 4'b0101;
    step(1);
    clr_i = 4'b0000;
    step(2);
`endif

    // Return to all-low before the simultaneous test.
    raw_i = 4'h0;
    push_exp(4'b0000, 4'b0101);
    step(15);

    // All channels together, up then down.
    raw_i = 4'hF;
    push_exp(4'hF, 4'h0);
    step(12);
    raw_i = 4'h0;
    push_exp(4'h0, 4'hF);
    step(12);

    // Channel 0 accepted high, then reset hits while channel 3 is at count 5.
    raw_i[0] = 1'b1;
    push_exp(4'b0001, 4'b0000);
    step(12);
    raw_i[3] = 1'b1;
    push_exp(4'b1000, 4'b0000);
    step(7);
    rst_n = 1'b0;
    #1;
    flush_model();
    check("reset_level", level_o, 4'h0);
    check("reset_rise", rise_o, 4'h0);
    check("reset_fall", fall_o, 4'h0);
    step(3);
    rst_n = 1'b1;
    push_exp(4'b1001, 4'b0000);
    step(15);

`ifdef DEBOUNCE_STICKY_EN
    clr_i = 4'b1000;
    step(1);
    clr_i = 4'b0000;
    step(3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
